// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and defaults for the SPI transfer sequencer.
// State encoding is fixed so the debug state output decodes the same everywhere.
package spi_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } xfer_state_e;

  localparam int unsigned LEN_W_DEF = 7;
  localparam int unsigned SS_NB_DEF = 8;
  localparam int unsigned DLY_W_DEF = 8;

  // A character length of 0 stands for the largest length, 2**len_w bits.
  function automatic int unsigned char_bits(input int unsigned len, input int unsigned len_w);
    return (len == 0) ? (32'd1 << len_w) : len;
  endfunction

endpackage

// File: rtl/spi_dly_cnt.sv
// Loadable down-counter with zero flag; times both SS setup and SS hold.
// Decrement saturates at zero so a late decrement request cannot wrap.
module spi_dly_cnt #(
  parameter int unsigned DLY_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DLY_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [DLY_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DLY_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: SS setup, bit transfer with tx/rx strobes, SS hold.
// start_i/abort_i are single-cycle pulses with no back-pressure; abort wins over start.
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned SS_NB = SS_NB_DEF,
  parameter int unsigned DLY_W = DLY_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] char_len_i,
  input  logic [SS_NB-1:0] ss_sel_i,
  input  logic             auto_ss_i,
  input  logic [DLY_W-1:0] ss_setup_i,
  input  logic [DLY_W-1:0] ss_hold_i,
  input  logic             tx_negedge_i,
  input  logic             rx_negedge_i,
  input  logic             pos_edge_i,
  input  logic             neg_edge_i,
  output logic             clk_en_o,
  output logic             go_o,
  output logic             last_clk_o,
  output logic             tx_shift_o,
  output logic             rx_sample_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [SS_NB-1:0] ss_no,
  output logic [LEN_W:0]   bit_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  xfer_state_e      state_q, state_d;
  logic [LEN_W:0]   bit_cnt_q;
  logic [SS_NB-1:0] ss_mask_q;
  logic             tx_neg_q, rx_neg_q;
  logic             clk_en_q, go_q, done_q;
  logic             dly_load, dly_hold, dly_dec, dly_zero;

  spi_dly_cnt #(.DLY_W(DLY_W)) u_dly_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (dly_load),
    .load_val_i (dly_hold ? ss_hold_i : ss_setup_i),
    .dec_i      (dly_dec),
    .zero_o     (dly_zero)
  );

  // Strobes are combinational from the generator edges; clk_en_q gates them to XFER.
  assign tx_shift_o  = clk_en_q & (tx_neg_q ? neg_edge_i : pos_edge_i);
  assign rx_sample_o = clk_en_q & (rx_neg_q ? neg_edge_i : pos_edge_i);
  assign last_clk_o  = clk_en_q & (bit_cnt_q == CNT_ONE);
  assign clk_en_o    = clk_en_q;
  assign go_o        = go_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign bit_cnt_o   = bit_cnt_q;
  assign ss_no       = auto_ss_i ? ~ss_mask_q : ~ss_sel_i;
  assign state_o     = state_q;

  always_comb begin
    state_d  = state_q;
    dly_load = 1'b0;
    dly_hold = 1'b0;
    dly_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_SETUP;
          dly_load = 1'b1;
        end
      end
      ST_SETUP: begin
        if (dly_zero) state_d = ST_XFER;
        else          dly_dec = 1'b1;
      end
      ST_XFER: begin
        if (rx_sample_o && (bit_cnt_q == CNT_ONE)) begin
          state_d  = ST_HOLD;
          dly_load = 1'b1;
          dly_hold = 1'b1;
        end
      end
      ST_HOLD: begin
        if (dly_zero) state_d = ST_IDLE;
        else          dly_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      ss_mask_q <= '0;
      tx_neg_q  <= 1'b0;
      rx_neg_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      go_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_en_q <= (state_d == ST_XFER);
      go_q     <= (state_q == ST_SETUP) && (state_d == ST_XFER);
      done_q   <= (state_q == ST_HOLD) && (state_d == ST_IDLE);
      if ((state_q == ST_IDLE) && start_i) begin
        bit_cnt_q <= (LEN_W+1)'(char_bits(32'(char_len_i), LEN_W));
        ss_mask_q <= ss_sel_i;
        tx_neg_q  <= tx_negedge_i;
        rx_neg_q  <= rx_negedge_i;
      end else if (rx_sample_o && (bit_cnt_q != '0)) begin
        bit_cnt_q <= bit_cnt_q - CNT_ONE;
      end
      if ((state_q == ST_HOLD) && (state_d == ST_IDLE)) ss_mask_q <= '0;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: directed scenarios plus randomized transfers,
// checked every cycle against a phase/count model of the sequencer.
module tb_spi_xfer_ctrl;
  import spi_xfer_ctrl_pkg::*;

  localparam int LEN_W = 7;
  localparam int SS_NB = 8;
  localparam int DLY_W = 8;
  localparam int P_IDLE = 0, P_SETUP = 1, P_XFER = 2, P_HOLD = 3;

  // clock / reset
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             rst_i, start_i, abort_i, auto_ss_i;
  logic [LEN_W-1:0] char_len_i;
  logic [SS_NB-1:0] ss_sel_i;
  logic [DLY_W-1:0] ss_setup_i, ss_hold_i;
  logic             tx_negedge_i, rx_negedge_i, pos_edge_i, neg_edge_i;
  logic             clk_en_o, go_o, last_clk_o, tx_shift_o, rx_sample_o, busy_o, done_o;
  logic [SS_NB-1:0] ss_no;
  logic [LEN_W:0]   bit_cnt_o;
  logic [1:0]       state_o;

  spi_xfer_ctrl #(.LEN_W(LEN_W), .SS_NB(SS_NB), .DLY_W(DLY_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .char_len_i(char_len_i), .ss_sel_i(ss_sel_i), .auto_ss_i(auto_ss_i),
    .ss_setup_i(ss_setup_i), .ss_hold_i(ss_hold_i),
    .tx_negedge_i(tx_negedge_i), .rx_negedge_i(rx_negedge_i),
    .pos_edge_i(pos_edge_i), .neg_edge_i(neg_edge_i),
    .clk_en_o(clk_en_o), .go_o(go_o), .last_clk_o(last_clk_o),
    .tx_shift_o(tx_shift_o), .rx_sample_o(rx_sample_o), .busy_o(busy_o),
    .done_o(done_o), .ss_no(ss_no), .bit_cnt_o(bit_cnt_o), .state_o(state_o)
  );

  int n_cmp = 0, n_err = 0, n_prints = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_prints < 40) begin
        n_prints++;
        $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
      end
    end
  endtask

  // behavioural model: phase plus cycles-left / bits-left counts
  int              m_phase = P_IDLE, m_left = 0, m_bits = 0;
  logic [SS_NB-1:0] m_sel = '0;
  logic            m_txn = 1'b0, m_rxn = 1'b0, m_first = 1'b0, m_done = 1'b0;
  logic [8:0]      exp_q[$];
  int              xfer_rx = 0;
  int c_go = 0, c_tx = 0, c_rx = 0, c_done = 0, c_last = 0, c_setup = 0, c_hold = 0;

  always @(negedge clk_i) begin : monitor
    logic             e_en, e_tx, e_rx;
    logic [SS_NB-1:0] e_mask, e_ss;
    e_en   = (m_phase == P_XFER);
    e_tx   = e_en && (m_txn ? neg_edge_i : pos_edge_i);
    e_rx   = e_en && (m_rxn ? neg_edge_i : pos_edge_i);
    e_mask = (m_phase != P_IDLE) ? m_sel : '0;
    e_ss   = auto_ss_i ? ~e_mask : ~ss_sel_i;
    chk("busy", 32'(busy_o), 32'(m_phase != P_IDLE));
    chk("clk_en", 32'(clk_en_o), 32'(e_en));
    chk("go", 32'(go_o), 32'(m_first));
    chk("done", 32'(done_o), 32'(m_done));
    chk("tx_shift", 32'(tx_shift_o), 32'(e_tx));
    chk("rx_sample", 32'(rx_sample_o), 32'(e_rx));
    chk("last_clk", 32'(last_clk_o), 32'(e_en && (m_bits == 1)));
    chk("bit_cnt", 32'(bit_cnt_o), 32'(m_bits));
    chk("ss_no", 32'(ss_no), 32'(e_ss));

    if (go_o) c_go++;
    if (tx_shift_o) c_tx++;
    if (rx_sample_o) begin c_rx++; xfer_rx++; end
    if (last_clk_o) c_last++;
    if (state_o == ST_SETUP) c_setup++;
    if (state_o == ST_HOLD) c_hold++;
    if (done_o) begin
      c_done++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rx_per_xfer @%0t: done with no transfer outstanding", $time);
      end else begin
        chk("rx_per_xfer", 32'(xfer_rx), 32'(exp_q.pop_front()));
      end
    end

    // advance model by one clock using the inputs the DUT will sample
    if (rst_i || abort_i) begin
      if (m_phase != P_IDLE && exp_q.size() > 0) void'(exp_q.pop_front());
      m_phase = P_IDLE; m_bits = 0; m_first = 1'b0; m_done = 1'b0;
    end else begin
      m_first = 1'b0; m_done = 1'b0;
      case (m_phase)
        P_IDLE: if (start_i) begin
          m_phase = P_SETUP;
          m_left  = int'(ss_setup_i) + 1;
          m_bits  = (char_len_i == '0) ? 128 : int'(char_len_i);
          m_sel = ss_sel_i; m_txn = tx_negedge_i; m_rxn = rx_negedge_i;
          exp_q.push_back(9'(m_bits));
          xfer_rx = 0;
        end
        P_SETUP: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_XFER; m_first = 1'b1; end
        end
        P_XFER: if (e_rx) begin
          m_bits--;
          if (m_bits == 0) begin m_phase = P_HOLD; m_left = int'(ss_hold_i) + 1; end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_IDLE; m_done = 1'b1; end
        end
      endcase
    end
  end

  // driver: clock generator stand-in plus pulse clearing
  int gen_div = 1, gen_cnt = 0;
  bit gen_next_neg = 1'b1, noise_en = 1'b1;

  task automatic tick();
    @(posedge clk_i);
    #1;
    start_i = 1'b0; abort_i = 1'b0; rst_i = 1'b0;
    pos_edge_i = 1'b0; neg_edge_i = 1'b0;
    if (clk_en_o) begin
      gen_cnt++;
      if (gen_cnt > gen_div) begin
        gen_cnt = 0;
        if (gen_next_neg) neg_edge_i = 1'b1; else pos_edge_i = 1'b1;
        gen_next_neg = !gen_next_neg;
      end
    end else begin
      gen_cnt = 0; gen_next_neg = 1'b1;
      pos_edge_i = noise_en && ($urandom_range(0, 2) == 0);
      neg_edge_i = noise_en && ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic clr_cnt();
    c_go = 0; c_tx = 0; c_rx = 0; c_done = 0; c_last = 0; c_setup = 0; c_hold = 0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy_o && k < budget) begin tick(); k++; end
    if (busy_o) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  task automatic cfg(input int len, input int setup, input int hold, input int div,
                     input logic txn, input logic rxn, input logic [SS_NB-1:0] sel);
    char_len_i = 7'(len); ss_setup_i = 8'(setup); ss_hold_i = 8'(hold); gen_div = div;
    tx_negedge_i = txn; rx_negedge_i = rxn; ss_sel_i = sel;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; auto_ss_i = 1'b1;
    pos_edge_i = 1'b0; neg_edge_i = 1'b0;
    cfg(8, 2, 1, 1, 1'b1, 1'b0, 8'h04);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_bit_cnt", 32'(bit_cnt_o), 32'd0);
    chk("rst_ss_no", 32'(ss_no), 32'hFF);

    // basic 8-bit transfer, tx on neg, rx on pos, divider 1
    clr_cnt();
    start_i = 1'b1; tick();
    chk("t1_ss_active", 32'(ss_no), 32'hFB);
    wait_idle(200); tick();
    chk("t1_setup_cycles", 32'(c_setup), 32'd3);
    chk("t1_go_count", 32'(c_go), 32'd1);
    chk("t1_tx_count", 32'(c_tx), 32'd8);
    chk("t1_rx_count", 32'(c_rx), 32'd8);
    chk("t1_last_cycles", 32'(c_last), 32'd4);
    chk("t1_hold_cycles", 32'(c_hold), 32'd2);
    chk("t1_done_count", 32'(c_done), 32'd1);
    chk("t1_ss_released", 32'(ss_no), 32'hFF);

    // length 0 means 128 bits
    cfg(0, 0, 0, 0, 1'b0, 1'b1, 8'h10);
    clr_cnt();
    start_i = 1'b1; tick();
    chk("t2_bit_cnt_start", 32'(bit_cnt_o), 32'd128);
    wait_idle(1000); tick();
    chk("t2_rx_count", 32'(c_rx), 32'd128);

    // abort after the third rx strobe
    cfg(8, 1, 1, 1, 1'b1, 1'b0, 8'h02);
    clr_cnt();
    start_i = 1'b1; tick();
    k = 0;
    while (c_rx < 3 && k < 200) begin tick(); k++; end
    chk("t3_reached_3rx", 32'(c_rx), 32'd3);
    abort_i = 1'b1; tick();
    chk("t3_busy", 32'(busy_o), 32'd0);
    chk("t3_clk_en", 32'(clk_en_o), 32'd0);
    chk("t3_ss_no", 32'(ss_no), 32'hFF);
    repeat (4) tick();
    chk("t3_no_done", 32'(c_done), 32'd0);
    cfg(5, 0, 0, 1, 1'b0, 1'b0, 8'h02);
    clr_cnt();
    start_i = 1'b1; tick();
    wait_idle(200); tick();
    chk("t3_restart_rx", 32'(c_rx), 32'd5);
    chk("t3_restart_done", 32'(c_done), 32'd1);

    // start with abort in idle; start pulsed mid-transfer
    start_i = 1'b1; abort_i = 1'b1; tick();
    chk("t4_stay_idle", 32'(state_o), 32'(ST_IDLE));
    cfg(6, 0, 0, 0, 1'b0, 1'b0, 8'h08);
    clr_cnt();
    start_i = 1'b1; tick();
    k = 0;
    while (c_rx < 2 && k < 100) begin tick(); k++; end
    start_i = 1'b1; tick();
    wait_idle(200); tick();
    chk("t4_rx_count", 32'(c_rx), 32'd6);
    chk("t4_done_count", 32'(c_done), 32'd1);

    // manual slave select follows ss_sel_i live
    auto_ss_i = 1'b0;
    ss_sel_i = 8'h01; #1;
    chk("t5_idle_sel01", 32'(ss_no), 32'hFE);
    ss_sel_i = 8'h80; #1;
    chk("t5_idle_sel80", 32'(ss_no), 32'h7F);
    cfg(4, 0, 0, 1, 1'b0, 1'b0, 8'h80);
    start_i = 1'b1; tick();
    k = 0;
    while (!clk_en_o && k < 50) begin tick(); k++; end
    ss_sel_i = 8'h01; #1;
    chk("t5_xfer_sel01", 32'(ss_no), 32'hFE);
    ss_sel_i = 8'h80; #1;
    chk("t5_xfer_sel80", 32'(ss_no), 32'h7F);
    wait_idle(200); tick();
    auto_ss_i = 1'b1;

    // reset during hold; edge noise while idle
    cfg(3, 0, 5, 0, 1'b0, 1'b0, 8'h20);
    start_i = 1'b1; tick();
    k = 0;
    while (state_o != ST_HOLD && k < 100) begin tick(); k++; end
    clr_cnt();
    rst_i = 1'b1; tick();
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_clk_en", 32'(clk_en_o), 32'd0);
    chk("t6_go", 32'(go_o), 32'd0);
    chk("t6_done", 32'(done_o), 32'd0);
    chk("t6_bit_cnt", 32'(bit_cnt_o), 32'd0);
    chk("t6_ss_no", 32'(ss_no), 32'hFF);
    repeat (20) tick();
    chk("t6_noise_tx", 32'(c_tx), 32'd0);
    chk("t6_noise_rx", 32'(c_rx), 32'd0);
    chk("t6_no_done", 32'(c_done), 32'd0);

    // randomized transfers with stray starts, aborts and resets
    for (int it = 0; it < 40; it++) begin
      cfg(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24),
          $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 2),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      auto_ss_i = ($urandom_range(0, 5) != 0);
      start_i = 1'b1; tick();
      k = 0;
      while (busy_o && k < 3000) begin
        if ($urandom_range(0, 199) == 0) abort_i = 1'b1;
        if ($urandom_range(0, 15) == 0) start_i = 1'b1;
        if ($urandom_range(0, 999) == 0) rst_i = 1'b1;
        char_len_i   = 7'($urandom);
        tx_negedge_i = 1'($urandom_range(0, 1));
        rx_negedge_i = 1'($urandom_range(0, 1));
        ss_setup_i   = 8'($urandom_range(0, 4));
        if (auto_ss_i) ss_sel_i = 8'($urandom);
        tick(); k++;
      end
      if (busy_o) begin
        n_cmp++; n_err++;
        $display("FAIL rand_timeout: transfer %0d still busy, expected idle", it);
      end
      repeat ($urandom_range(1, 3)) tick();
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI host. It drives the SPI clock generator's enable, go and last_clk inputs and consumes its pos_edge/neg_edge pulses. It counts transferred bits, emits tx-shift and rx-sample strobes to the shift register, and times slave-select setup and hold. It sits between the SPI register block (start, abort, config) and the clock generator / shift register.

Parameters:
LEN_W, 7, character-length field width; length 0 encodes 2**LEN_W bits (128)
SS_NB, 8, number of slave-select lines
DLY_W, 8, width of the SS setup/hold delay fields

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start transfer pulse; ignored unless IDLE
abort_i  in  1  abort pulse; forces IDLE from any state
char_len_i  in  LEN_W  bits per transfer (0 = 128)
ss_sel_i  in  SS_NB  slave select mask
auto_ss_i  in  1  1 = block drives SS automatically; 0 = ss_no follows ~ss_sel_i live
ss_setup_i  in  DLY_W  SS-to-first-clock delay, in cycles
ss_hold_i  in  DLY_W  last-clock-to-SS-release delay, in cycles
tx_negedge_i  in  1  1 = shift tx on neg_edge_i, else on pos_edge_i
rx_negedge_i  in  1  1 = sample rx on neg_edge_i, else on pos_edge_i
pos_edge_i  in  1  from clock generator
neg_edge_i  in  1  from clock generator
clk_en_o  out  1  clock generator enable
go_o  out  1  clock generator go pulse
last_clk_o  out  1  clock generator last_clk
tx_shift_o  out  1  shift-register tx strobe
rx_sample_o  out  1  shift-register rx strobe
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
ss_no  out  SS_NB  active-low slave selects
bit_cnt_o  out  LEN_W+1  bits remaining

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: state IDLE; clk_en_o, go_o, done_o, busy_o = 0; bit_cnt_o = 0; latched SS mask = 0, so ss_no = all ones when auto_ss_i = 1.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE, start_i = 1:
  - Latch char_len (0 maps to 128) into bit_cnt, latch ss_sel_i, tx_negedge_i and rx_negedge_i.
  - Load the delay counter with ss_setup_i.
  - Go to SETUP; if auto_ss, assert the latched SS lines the next cycle.
  - Config inputs are don't-care after the latch.
- SETUP:
  - If delay counter == 0: go to XFER and pulse go_o for exactly one cycle (the first XFER cycle). Otherwise decrement.
  - ss_setup = N gives N+1 cycles in SETUP.
- XFER:
  - clk_en_o = 1 (registered, high from the first XFER cycle until the cycle after leaving XFER).
  - tx_shift_o = clk_en_o & (latched tx_negedge ? neg_edge_i : pos_edge_i); combinational, zero latency.
  - rx_sample_o likewise, using the latched rx_negedge selection.
  - bit_cnt decrements on every rx_sample_o.
  - last_clk_o = clk_en_o & (bit_cnt == 1).
  - An rx_sample_o with bit_cnt == 1 sets bit_cnt to 0, loads the delay counter with ss_hold_i and goes to HOLD.
  - Simultaneous tx and rx strobes are legal and both are emitted.
- HOLD:
  - clk_en_o = 0; edge inputs are ignored; no strobes.
  - Counter == 0: release SS (auto mode), pulse done_o for one cycle, go to IDLE. Otherwise decrement. ss_hold = M gives M+1 HOLD cycles.
  - start_i during HOLD is ignored.
- abort_i:
  - Any state goes to IDLE next cycle; clk_en_o = 0, SS released, bit_cnt = 0, no done_o.
  - abort_i wins over start_i in the same cycle.
- Reset mid-transfer: identical to abort; all outputs take reset values.
- start_i in SETUP/XFER/HOLD: ignored, no state change.
- Edge pulses while not in XFER never produce strobes or count.
- Delay counter and bit_cnt never wrap: decrements are gated at 0.

Decomposition:
- Shared defines include gets the state encodings (2-bit: IDLE=0, SETUP=1, XFER=2, HOLD=3), the LEN_W/SS_NB/DLY_W defaults, and the "length 0 = max" constant.
- One natural sub-module: spi_dly_cnt, a loadable DLY_W down-counter with a zero flag. It is shared by SETUP and HOLD; the reload selects ss_setup_i or ss_hold_i.

Test Plan:
- char_len=8, setup=2, hold=1, auto_ss, ss_sel=8'h04, tx neg / rx pos, edges from a real clock generator with divider 1 -> ss_no=8'hFB for the whole transfer, 3 SETUP cycles, one go_o, 8 tx and 8 rx strobes, last_clk_o high only while bit_cnt=1, 2 HOLD cycles, done_o once, ss_no=8'hFF.
- char_len=0, divider 0 -> exactly 128 rx_sample_o; bit_cnt_o starts at 128.
- abort_i after the 3rd rx strobe -> next cycle IDLE, clk_en_o=0, ss_no=8'hFF, no done_o; a following start works normally.
- start_i and abort_i together in IDLE -> stays IDLE; start_i pulsed mid-XFER -> ignored, bit count unaffected.
- auto_ss=0, ss_sel toggled 8'h01→8'h80 while IDLE and XFER -> ss_no tracks ~ss_sel_i the same cycle.
- rst_i asserted in HOLD -> all outputs at reset values next cycle; pos/neg pulses injected in IDLE -> no strobes.
